// File: rtl/disp_pkg.sv
// Shared types and sizing helpers for the display scan controller.
// Imported by the scan FSM and its rotating-priority helper.
package disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } scan_state_t;

    localparam int MAX_DIGITS = 8;

    // Wide enough for the largest supported digit count; consumers slice it.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Rotating-priority finder: first set mask bit strictly after idx, modulo N.
// wrap flags that the search went past the top back to an index <= idx.
module rr_next_sel
    import disp_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] idx,
    output logic [IW-1:0] nxt,
    output logic          any_en,
    output logic          wrap
);

    int cand;

    always_comb begin
        nxt    = '0;
        cand   = 0;
        any_en = |mask;
        // Walk offsets from farthest to nearest so the nearest enabled index wins.
        for (int k = N; k >= 1; k--) begin
            cand = (int'(idx) + k) % N;
            if (mask[cand]) begin
                nxt = IW'(cand);
            end
        end
        wrap = any_en && (nxt <= idx);
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexes N_DIGITS BCD sources onto one shared 7-segment decoder,
// driving active-low anodes with blank dead time between lit digits.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS        = 4,
    parameter int TICKS_PER_DIGIT = 8,
    parameter int BLANK_TICKS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    output logic [3:0]            bcd_sel,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_done
);

    localparam int IW = idx_width(N_DIGITS);
    localparam int TW = timer_width(TICKS_PER_DIGIT, BLANK_TICKS);

    localparam logic [N_DIGITS-1:0] AN_OFF     = ANODE_OFF[N_DIGITS-1:0];
    localparam logic [TW-1:0]       BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0]       SCAN_LAST  = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [IW-1:0]       IDX_RESET  = IW'(N_DIGITS - 1);

    scan_state_t   state;
    logic [IW-1:0] idx;
    logic [TW-1:0] timer;

    logic [IW-1:0] nxt;
    logic          any_en;
    logic          wrap;

    rr_next_sel #(
        .N  (N_DIGITS),
        .IW (IW)
    ) u_rr_next_sel (
        .mask   (digit_en),
        .idx    (idx),
        .nxt    (nxt),
        .any_en (any_en),
        .wrap   (wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BLANK;
            idx        <= IDX_RESET;
            timer      <= '0;
            an_out     <= AN_OFF;
            bcd_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                BLANK: begin
                    if (timer == BLANK_LAST) begin
                        timer <= '0;
                        // With nothing enabled the blank period simply repeats.
                        if (any_en) begin
                            idx        <= nxt;
                            bcd_sel    <= digits_in[4*int'(nxt) +: 4];
                            an_out     <= ~(N_DIGITS'(1) << nxt);
                            frame_done <= wrap;
                            state      <= SCAN;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SCAN: begin
                    // bcd_sel is left alone so it never moves under a lit anode.
                    if (timer == SCAN_LAST) begin
                        timer  <= '0;
                        an_out <= AN_OFF;
                        state  <= BLANK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state  <= BLANK;
                    timer  <= '0;
                    an_out <= AN_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: directed tables, corner sequences
// and a randomized run against a slot-countdown reference model.
module tb_disp_scan_ctrl;

    localparam int N   = 4;
    localparam int TPD = 8;
    localparam int BT  = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4*N-1:0]   digits_in;
    logic [N-1:0]     digit_en;
    logic [3:0]       bcd_sel;
    logic [N-1:0]     an_out;
    logic             frame_done;

    disp_scan_ctrl #(
        .N_DIGITS        (N),
        .TICKS_PER_DIGIT (TPD),
        .BLANK_TICKS     (BT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .digit_en   (digit_en),
        .bcd_sel    (bcd_sel),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int edge_n = 0;

    // Reference model: which digit is shown and how many cycles remain in the phase.
    int         m_idx;
    bit         m_lit;
    int         m_left;
    logic [3:0] m_bcd;
    logic [N-1:0] m_an;
    logic       m_fd;

    typedef struct {
        int           at_edge;
        logic [N-1:0] an;
        logic [3:0]   bcd;
        logic         fd;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
        end
    endtask

    task automatic model_reset();
        m_idx  = N - 1;
        m_lit  = 1'b0;
        m_left = BT;
        m_bcd  = 4'h0;
        m_an   = '1;
        m_fd   = 1'b0;
    endtask

    task automatic model_edge();
        int  n;
        bit  found;
        if (!reset) begin
            model_reset();
            return;
        end
        m_fd   = 1'b0;
        m_left = m_left - 1;
        if (m_left > 0) return;
        if (m_lit) begin
            m_lit  = 1'b0;
            m_an   = '1;
            m_left = BT;
        end else if (digit_en == '0) begin
            m_left = BT;
        end else begin
            found = 1'b0;
            n = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && digit_en[(m_idx + k) % N]) begin
                    n = (m_idx + k) % N;
                    found = 1'b1;
                end
            end
            m_fd   = (n <= m_idx);
            m_idx  = n;
            m_bcd  = digits_in[4*n +: 4];
            m_an   = '1;
            m_an[n] = 1'b0;
            m_lit  = 1'b1;
            m_left = TPD;
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        check("model_an", 32'(an_out), 32'(m_an));
        check("model_bcd", 32'(bcd_sel), 32'(m_bcd));
        check("model_fd", 32'(frame_done), 32'(m_fd));
        check("one_cold", 32'($countones(~an_out) <= 1), 32'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_an"}, 32'(an_out), 32'hF);
        check({tag, "_bcd"}, 32'(bcd_sel), 32'h0);
        check({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    // Assert reset away from the clock edge, check the async clear, then release.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        repeat (2) step();
        reset  = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        int fd_cnt;
        int bad_cnt;
        bit seen;

        tbl[0] = '{1,  4'b1110, 4'h3, 1'b1};
        tbl[1] = '{2,  4'b1110, 4'h3, 1'b0};
        tbl[2] = '{8,  4'b1110, 4'h3, 1'b0};
        tbl[3] = '{9,  4'b1111, 4'h3, 1'b0};
        tbl[4] = '{10, 4'b1101, 4'h5, 1'b0};
        tbl[5] = '{18, 4'b1111, 4'h5, 1'b0};
        tbl[6] = '{19, 4'b1011, 4'h8, 1'b0};
        tbl[7] = '{28, 4'b0111, 4'hD, 1'b0};
        tbl[8] = '{36, 4'b1111, 4'hD, 1'b0};
        tbl[9] = '{37, 4'b1110, 4'h3, 1'b1};

        digits_in = 16'hD853;
        digit_en  = 4'b1111;
        reset     = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();

        // Reset held, then a release/re-assert pulse with no clock edge in between.
        repeat (3) step();
        check_reset_vals("rst_hold");
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("rst_midcycle");
        model_reset();
        step();
        reset  = 1'b1;
        edge_n = 0;

        // Basic scan against hand-derived checkpoints.
        for (int i = 0; i < 10; i++) begin
            while (edge_n < tbl[i].at_edge) step();
            check($sformatf("basic_an_e%0d", tbl[i].at_edge), 32'(an_out), 32'(tbl[i].an));
            check($sformatf("basic_bcd_e%0d", tbl[i].at_edge), 32'(bcd_sel), 32'(tbl[i].bcd));
            check($sformatf("basic_fd_e%0d", tbl[i].at_edge), 32'(frame_done), 32'(tbl[i].fd));
        end

        // Hold stability: digit 0 changes mid-slot.
        do_reset();
        digits_in = 16'hD853;
        while (edge_n < 4) step();
        digits_in[3:0] = 4'h7;
        while (edge_n < 9) begin
            step();
            check("hold_bcd", 32'(bcd_sel), 32'h3);
        end
        while (edge_n < 37) step();
        check("hold_next_bcd", 32'(bcd_sel), 32'h7);
        check("hold_next_an", 32'(an_out), 32'b1110);

        // Reset in the middle of digit 2's slot.
        while (edge_n < 57) step();
        check("mid_an_d2", 32'(an_out), 32'b1011);
        do_reset();
        step();
        check("restart_an", 32'(an_out), 32'b1110);
        check("restart_bcd", 32'(bcd_sel), 32'h7);
        check("restart_fd", 32'(frame_done), 32'h1);

        // Mask skip: only digits 0 and 2.
        do_reset();
        digit_en = 4'b0101;
        fd_cnt = 0;
        while (edge_n < 36) begin
            step();
            if (frame_done) fd_cnt++;
            if (edge_n == 1)  check("skip_an_e1", 32'(an_out), 32'b1110);
            if (edge_n == 10) check("skip_an_e10", 32'(an_out), 32'b1011);
            if (edge_n == 19) check("skip_an_e19", 32'(an_out), 32'b1110);
            if (edge_n == 28) check("skip_an_e28", 32'(an_out), 32'b1011);
        end
        check("skip_fd_count", 32'(fd_cnt), 32'd2);

        // All disabled, then enable only digit 3.
        do_reset();
        digit_en = 4'b0000;
        bad_cnt = 0;
        repeat (50) begin
            step();
            if (an_out !== 4'b1111 || frame_done !== 1'b0) bad_cnt++;
        end
        check("dis_quiet", 32'(bad_cnt), 32'd0);
        digit_en = 4'b1000;
        seen = 1'b0;
        for (int i = 0; i < BT + 1 && !seen; i++) begin
            step();
            if (an_out == 4'b0111) begin
                seen = 1'b1;
                check("dis_wake_fd", 32'(frame_done), 32'h1);
                check("dis_wake_bcd", 32'(bcd_sel), 32'hD);
            end
        end
        check("dis_wake_lit", 32'(seen), 32'h1);

        // Randomized mask and source changes.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) digits_in = 16'($urandom);
            if ($urandom_range(0, 24) == 0)
                digit_en = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
